// File: rtl/oversampled_frame_tx_pkg.sv
// Shared definitions for the oversampled frame transmitter and its matching
// receive correlator: default frame geometry, sync pattern and FSM encoding.
// Optional feature macro: FRAME_TX_PARITY_EN (adds a trailing even-parity bit).
package oversampled_frame_tx_pkg;

  localparam int DEF_SAMPLES       = 2;
  localparam int DEF_OSF           = 8;
  localparam int DEF_PREAMBLE_REPS = 4;
  localparam int DEF_PAYLOAD_BITS  = 8;

  // Sync pattern the receive correlator is matched against, sent MSB first.
  localparam logic [DEF_SAMPLES-1:0] DEFAULT_SYNC_WORD = 2'b10;

`ifdef FRAME_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int FRAME_BITS    = DEF_PREAMBLE_REPS * DEF_SAMPLES + DEF_PAYLOAD_BITS + PARITY_BITS;
  localparam int FRAME_SAMPLES = FRAME_BITS * DEF_OSF;

`ifdef FRAME_TX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_PARITY   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/oversampled_frame_tx_oversample_ticker.sv
// Sample-tick counter for the frame transmitter. Counts Enable-qualified
// ticks while a frame runs and strobes bit_adv_o on the last tick of a bit.
module oversample_ticker #(
  parameter int OSF = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic run_i,
  input  logic clr_i,
  output logic bit_adv_o
);

  localparam int TW = (OSF > 1) ? $clog2(OSF) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OSF - 1);

  logic [TW-1:0] tick_q;

  // Tick counter: cleared on frame acceptance, wraps after OSF enabled ticks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q <= '0;
    end else if (clr_i) begin
      tick_q <= '0;
    end else if (run_i && en_i) begin
      if (tick_q == TICK_LAST) begin
        tick_q <= '0;
      end else begin
        tick_q <= tick_q + TW'(1);
      end
    end else begin
      tick_q <= tick_q;
    end
  end

  assign bit_adv_o = run_i & en_i & (tick_q == TICK_LAST);

endmodule

// File: rtl/oversampled_frame_tx.sv
// Oversampled frame transmitter: PREAMBLE_REPS copies of the sync word, then
// the latched payload MSB first, each bit held for OSF Enable ticks.
// Optional feature macro: FRAME_TX_PARITY_EN (even-parity bit after payload).
module oversampled_frame_tx
  import oversampled_frame_tx_pkg::*;
#(
  parameter int SAMPLES       = DEF_SAMPLES,
  parameter int OSF           = DEF_OSF,
  parameter logic [SAMPLES-1:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter int PREAMBLE_REPS = DEF_PREAMBLE_REPS,
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    Start,
  input  logic [PAYLOAD_BITS-1:0] DataIn,
  output logic                    Ready,
  output logic                    Busy,
  output logic                    DataOut,
  output logic                    Done
);

  localparam int BW = (SAMPLES > 1)       ? $clog2(SAMPLES)       : 1;
  localparam int RW = (PREAMBLE_REPS > 1) ? $clog2(PREAMBLE_REPS) : 1;
  localparam int PW = (PAYLOAD_BITS > 1)  ? $clog2(PAYLOAD_BITS)  : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(SAMPLES - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(PREAMBLE_REPS - 1);
  localparam logic [PW-1:0] PAY_LAST = PW'(PAYLOAD_BITS - 1);

  state_t                  state_q;
  logic [BW-1:0]           bit_q;
  logic [RW-1:0]           rep_q;
  logic [PW-1:0]           pay_q;
  logic [PAYLOAD_BITS-1:0] shreg_q;
  logic [SAMPLES-1:0]      sync_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    dout_q;
  logic                    done_q;
  logic                    accept_s;
  logic                    bit_adv_s;
  logic [PAYLOAD_BITS-1:0] shreg_d;
  logic [SAMPLES-1:0]      sync_d;

`ifdef FRAME_TX_PARITY_EN
  logic parity_q;

  function automatic logic even_parity(input logic [PAYLOAD_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  assign accept_s = (state_q == ST_IDLE) && Start;
  // Shifted payload and rotated sync word: the MSB of each is the next bit out.
  assign shreg_d  = shreg_q << 1;
  assign sync_d   = (sync_q << 1) | (sync_q >> (SAMPLES - 1));

  oversample_ticker #(
    .OSF (OSF)
  ) u_ticker (
    .clk_i     (Clk),
    .rst_ni    (Reset),
    .en_i      (Enable),
    .run_i     (busy_q),
    .clr_i     (accept_s),
    .bit_adv_o (bit_adv_s)
  );

  // Frame sequencer: state, bit/rep/payload counters and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      rep_q   <= '0;
      pay_q   <= '0;
      shreg_q <= '0;
      sync_q  <= SYNC_WORD;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FRAME_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            shreg_q <= DataIn;
            sync_q  <= SYNC_WORD;
            bit_q   <= '0;
            rep_q   <= '0;
            pay_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            dout_q  <= SYNC_WORD[SAMPLES-1];
            state_q <= ST_PREAMBLE;
`ifdef FRAME_TX_PARITY_EN
            parity_q <= even_parity(DataIn);
`endif
          end else begin
            dout_q <= 1'b0;
          end
        end
        ST_PREAMBLE: begin
          if (bit_adv_s) begin
            sync_q <= sync_d;
            if (bit_q == BIT_LAST) begin
              bit_q <= '0;
              if (rep_q == REP_LAST) begin
                rep_q   <= '0;
                dout_q  <= shreg_q[PAYLOAD_BITS-1];
                state_q <= ST_PAYLOAD;
              end else begin
                rep_q  <= rep_q + RW'(1);
                dout_q <= sync_d[SAMPLES-1];
              end
            end else begin
              bit_q  <= bit_q + BW'(1);
              dout_q <= sync_d[SAMPLES-1];
            end
          end else begin
            dout_q <= dout_q;
          end
        end
        ST_PAYLOAD: begin
          if (bit_adv_s) begin
            shreg_q <= shreg_d;
            if (pay_q == PAY_LAST) begin
              pay_q <= '0;
`ifdef FRAME_TX_PARITY_EN
              dout_q  <= parity_q;
              state_q <= ST_PARITY;
`else
              dout_q  <= 1'b0;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
`endif
            end else begin
              pay_q  <= pay_q + PW'(1);
              dout_q <= shreg_d[PAYLOAD_BITS-1];
            end
          end else begin
            dout_q <= dout_q;
          end
        end
`ifdef FRAME_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_adv_s) begin
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            dout_q <= dout_q;
          end
        end
`endif
        default: begin
          dout_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Ready   = ready_q;
  assign Busy    = busy_q;
  assign DataOut = dout_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_oversampled_frame_tx.sv
// Directed bench for oversampled_frame_tx (default geometry: 2-bit sync 10,
// 4 repetitions, 8 payload bits, 8 samples per bit).
module tb_oversampled_frame_tx;

`ifdef FRAME_TX_PARITY_EN
  localparam int FRAME = 136;
`else
  localparam int FRAME = 128;
`endif

  logic       Clk;
  logic       Reset;
  logic       Enable;
  logic       Start;
  logic [7:0] DataIn;
  logic       Ready;
  logic       Busy;
  logic       DataOut;
  logic       Done;

  int n_checks;
  int n_errors;

  oversampled_frame_tx dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Enable  (Enable),
    .Start   (Start),
    .DataIn  (DataIn),
    .Ready   (Ready),
    .Busy    (Busy),
    .DataOut (DataOut),
    .Done    (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected sample idx of a frame: sync 10 x4 (8 bits), payload MSB first, parity.
  function automatic logic exp_sample(input logic [7:0] d, input int idx);
    int b;
    b = idx / 8;
    if (b < 8) return (b % 2) == 0;
    else if (b < 16) return d[3'(15 - b)];
    else return ^d;
  endfunction

  // Issue Start at a negedge in IDLE, check every sample, then Done and idle.
  task automatic run_frame(input logic [7:0] data, input int glitch_at);
    int dones;
    dones = 0;
    Start  = 1'b1;
    DataIn = data;
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      chk("busy", Busy, 1);
      chk("ready", Ready, 0);
      chk("dout", DataOut, exp_sample(data, i));
      if (Done) dones++;
      Start  = (i == glitch_at);
      DataIn = (i == glitch_at) ? ~data : data;
      @(negedge Clk);
    end
    Start = 1'b0;
    chk("done_end", Done, 1);
    chk("ready_end", Ready, 1);
    chk("busy_end", Busy, 0);
    chk("dout_end", DataOut, 0);
    @(negedge Clk);
    chk("done_once", Done, 0);
    chk("dones_in_frame", dones, 0);
  endtask

  initial begin
    int k;
    int cnt;
    n_checks = 0;
    n_errors = 0;
    Reset  = 1'b0;
    Enable = 1'b1;
    Start  = 1'b0;
    DataIn = 8'h00;
    repeat (2) @(negedge Clk);
    chk("rst_ready", Ready, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_dout", DataOut, 0);
    chk("rst_done", Done, 0);
    Reset = 1'b1;
    @(negedge Clk);

    // Basic frame, Enable held high.
    run_frame(8'hA5, -1);

    // Enable toggling: accept with Enable=1, then 0,1,0,...
    Start  = 1'b1;
    DataIn = 8'h3C;
    @(negedge Clk);
    Start = 1'b0;
    k = 1;
    while (Busy && k < 4 * FRAME) begin
      chk("tog_dout", DataOut, exp_sample(8'h3C, (k - 1) / 2));
      Enable = (k % 2) == 0;
      @(negedge Clk);
      k++;
    end
    chk("tog_len", k - 1, 2 * FRAME);
    chk("tog_done", Done, 1);
    Enable = 1'b1;
    @(negedge Clk);

    // Start pulse mid-frame is ignored.
    run_frame(8'h5A, 40);

    // Asynchronous reset at sample 70, no Done, then a full frame.
    Start  = 1'b1;
    DataIn = 8'hFF;
    @(negedge Clk);
    Start = 1'b0;
    repeat (70) @(negedge Clk);
    chk("pre_rst_busy", Busy, 1);
    #2 Reset = 1'b0;
    #1;
    chk("arst_dout", DataOut, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_ready", Ready, 1);
    chk("arst_done", Done, 0);
    @(negedge Clk);
    Reset = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Done || Busy) cnt++;
    end
    chk("arst_quiet", cnt, 0);
    run_frame(8'hC3, -1);

    // Parity-relevant payload (odd ones count).
    run_frame(8'h07, -1);

    // Back-to-back: Start held high.
    Start  = 1'b1;
    DataIn = 8'h81;
    @(negedge Clk);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        chk("b2b_dout", DataOut, exp_sample(8'h81, i));
        chk("b2b_busy", Busy, 1);
        @(negedge Clk);
      end
      chk("b2b_done", Done, 1);
      chk("b2b_gap_dout", DataOut, 0);
      chk("b2b_gap_busy", Busy, 0);
      if (f == 1) Start = 1'b0;
      @(negedge Clk);
    end
    chk("b2b_idle", Busy, 0);
    chk("b2b_idle_done", Done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
